pipelined_rca_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor; next generation of the fixed-width combinational RCA blocks.
- Splits a WIDTH-bit add into WIDTH/SEG segments, one segment per pipeline stage; carry is registered between stages.
- Accepts one operation per cycle through a valid/ready handshake.
- Produces sum, carry-out and signed-overflow flags; sits in the datapath wherever wide adds exceed single-cycle timing.

---
 rtl/pipelined_rca_adder_if.sv | 33 +++
 rtl/pipelined_rca_adder.sv | 111 +++++++++++
 tb/tb_pipelined_rca_adder.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_rca_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder_if
// Handshake bundle for the pipelined ripple-carry adder/subtractor.
//   Request  : in_valid / in_ready, operands a, b, carry-in cin, sub select.
//   Response : out_valid / out_ready, sum, cout, ovf.
// master : the block that issues operations and consumes results.
// slave  : the adder itself.
// ---------------------------------------------------------------------------
interface pipelined_rca_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_rca_adder.sv
// ---------------------------------------------------------------------------
// pipelined_rca_adder
// Pipelined ripple-carry adder/subtractor. A WIDTH-bit add is cut into
// STAGES = WIDTH/SEG segments; each pipeline stage ripples one SEG-bit
// segment and registers its carry for the next stage. Latency is STAGES
// cycles from the accepting edge, throughput one operation per cycle.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high (clears valid bits only)
//   bus  : slave side of pipelined_rca_adder_if
//          in_valid/in_ready, a, b, cin, sub   -> operation request
//          out_valid/out_ready, sum, cout, ovf -> result
// sub=1 computes a + ~b + 1 (cin ignored); cout=1 then means "no borrow".
// ovf is the signed overflow: carry into the MSB XOR carry out of the MSB.
// ---------------------------------------------------------------------------
module pipelined_rca_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_rca_adder_if.slave  bus
);
    localparam int STAGES = WIDTH / SEG;

    if (SEG <= 0 || (WIDTH % SEG) != 0) begin : g_bad_seg
        $error("pipelined_rca_adder: WIDTH must be a multiple of SEG");
    end

    // Ripple a single segment. Returns {carry_out, carry_into_msb, sum}.
    function automatic logic [SEG+1:0] rca_seg(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0] s;
        logic           c;
        logic           c_msb;
        c     = ci;
        c_msb = ci;
        s     = '0;
        for (int i = 0; i < SEG; i++) begin
            if (i == SEG - 1) c_msb = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_msb, s};
    endfunction

    // Level k holds an operation with segments 0..k-1 already summed.
    // Level 0 is the accept register, level STAGES drives the outputs.
    logic             vld_p   [0:STAGES];
    logic             carry_p [0:STAGES];
    logic [WIDTH-1:0] sum_p   [0:STAGES];
    logic [WIDTH-1:0] aop_p   [0:STAGES-1];
    logic [WIDTH-1:0] bop_p   [0:STAGES-1];
    logic             ovf_p;

    logic             adv;
    logic [SEG+1:0]   seg_res [0:STAGES-1];
    logic [WIDTH-1:0] sum_nxt [0:STAGES-1];

    // Single global enable: the whole pipe moves unless a result is stuck.
    assign adv = !vld_p[STAGES] || bus.out_ready;

    // ---- stage k: ripple segment k between level k and level k+1 ----
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = rca_seg(aop_p[k][k*SEG +: SEG],
                                 bop_p[k][k*SEG +: SEG],
                                 carry_p[k]);
            sum_nxt[k] = sum_p[k];
            sum_nxt[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
        end
    end

    // ---- control: valid bits, the only reset state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) vld_p[k] <= 1'b0;
        end else if (adv) begin
            vld_p[0] <= bus.in_valid;
            for (int k = 1; k <= STAGES; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // ---- datapath: level 0 captures effective operands, later levels shift ----
    always_ff @(posedge clk) begin
        if (adv) begin
            aop_p[0]   <= bus.a;
            bop_p[0]   <= bus.sub ? ~bus.b : bus.b;
            carry_p[0] <= bus.sub | bus.cin;
            sum_p[0]   <= '0;
            for (int k = 1; k < STAGES; k++) begin
                aop_p[k] <= aop_p[k-1];
                bop_p[k] <= bop_p[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                sum_p[k+1]   <= sum_nxt[k];
                carry_p[k+1] <= seg_res[k][SEG+1];
            end
            ovf_p <= seg_res[STAGES-1][SEG+1] ^ seg_res[STAGES-1][SEG];
        end
    end

    // ---- output: data is not reset, so mask it while no result is held ----
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_p[STAGES];
    assign bus.sum       = vld_p[STAGES] ? sum_p[STAGES] : '0;
    assign bus.cout      = vld_p[STAGES] & carry_p[STAGES];
    assign bus.ovf       = vld_p[STAGES] & ovf_p;
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_rca_adder
// Bench for pipelined_rca_adder: three instances (64/8, 32/32, 16/4) checked
// against an arithmetic reference model and a result queue.
// ---------------------------------------------------------------------------
module tb_pipelined_rca_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipelined_rca_adder_if #(.WIDTH(64)) bus64 ();
    pipelined_rca_adder_if #(.WIDTH(32)) bus32 ();
    pipelined_rca_adder_if #(.WIDTH(16)) bus16 ();

    pipelined_rca_adder #(.WIDTH(64), .SEG(8))  dut64 (.clk(clk), .rst(rst), .bus(bus64));
    pipelined_rca_adder #(.WIDTH(32), .SEG(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    pipelined_rca_adder #(.WIDTH(16), .SEG(4))  dut16 (.clk(clk), .rst(rst), .bus(bus16));

    // Reference: plain wide arithmetic on the low w bits. Returns {ovf, cout, sum}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic cin,
                                            input logic sub);
        logic [63:0] mask, am, beff, s;
        logic [64:0] t;
        logic        c, o;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        beff = (sub ? ~b : b) & mask;
        t    = {1'b0, am} + {1'b0, beff} + (sub ? 65'd1 : {64'd0, cin});
        s    = t[63:0] & mask;
        c    = t[w];
        // Same-sign operands giving a different-sign result is signed overflow.
        o    = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
        return {o, c, s};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || bus64.sum !== 64'd0 ||
            bus64.cout !== 1'b0 || bus64.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset64 got vld=%b rdy=%b sum=%h cout=%b ovf=%b expected 0 1 0 0 0",
                     bus64.out_valid, bus64.in_ready, bus64.sum, bus64.cout, bus64.ovf);
        end
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.sum !== 32'd0) begin
            errors++;
            $display("FAIL reset32 got vld=%b rdy=%b sum=%h expected 0 1 0",
                     bus32.out_valid, bus32.in_ready, bus32.sum);
        end
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.sum !== 16'd0) begin
            errors++;
            $display("FAIL reset16 got vld=%b rdy=%b sum=%h expected 0 1 0",
                     bus16.out_valid, bus16.in_ready, bus16.sum);
        end
    endtask

    task automatic test_directed();
        logic [63:0] va [4], vb [4], vs [4];
        logic        vc [4], vsub [4], vco [4], vov [4];
        int          lat;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd0; vc[0] = 1'b1; vsub[0] = 1'b0;
        vs[0] = 64'd0;                   vco[0] = 1'b1; vov[0] = 1'b0;
        va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'd1; vc[1] = 1'b0; vsub[1] = 1'b0;
        vs[1] = 64'h8000_0000_0000_0000; vco[1] = 1'b0; vov[1] = 1'b1;
        va[2] = 64'd5; vb[2] = 64'd7; vc[2] = 1'b0; vsub[2] = 1'b1;
        vs[2] = 64'hFFFF_FFFF_FFFF_FFFE; vco[2] = 1'b0; vov[2] = 1'b0;
        va[3] = 64'd7; vb[3] = 64'd5; vc[3] = 1'b1; vsub[3] = 1'b1;
        vs[3] = 64'd2;                   vco[3] = 1'b1; vov[3] = 1'b0;
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus64.a = va[i]; bus64.b = vb[i]; bus64.cin = vc[i]; bus64.sub = vsub[i];
            bus64.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus64.in_valid = 1'b0;
            lat = 0;
            while (bus64.out_valid !== 1'b1 && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL latency64 vec%0d got %0d expected 8", i, lat);
            end
            checks++;
            if (bus64.sum !== vs[i] || bus64.cout !== vco[i] || bus64.ovf !== vov[i]) begin
                errors++;
                $display("FAIL directed64 vec%0d got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                         i, bus64.sum, bus64.cout, bus64.ovf, vs[i], vco[i], vov[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus64.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL no_dup64 vec%0d got out_valid=%b expected 0", i, bus64.out_valid);
            end
        end
    endtask

    task automatic test_streaming();
        logic [65:0] q [$];
        logic [65:0] got;
        int          first, last, nvalid;
        first = -1; last = -1; nvalid = 0;
        bus64.out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (bus64.out_valid === 1'b1) begin
                if (first < 0) first = t;
                last = t;
                nvalid++;
                got = {bus64.ovf, bus64.cout, bus64.sum};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream64 t=%0d got unexpected result %h expected none", t, got);
                end else begin
                    if (got !== q[0]) begin
                        errors++;
                        $display("FAIL stream64 t=%0d got %h expected %h", t, got, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (t < 16) begin
                bus64.a = rnd64(); bus64.b = rnd64();
                bus64.cin = $urandom_range(0, 1) == 1; bus64.sub = $urandom_range(0, 1) == 1;
                bus64.in_valid = 1'b1;
                checks++;
                if (bus64.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream64_ready t=%0d got %b expected 1", t, bus64.in_ready);
                end
                q.push_back(ref_add(64, bus64.a, bus64.b, bus64.cin, bus64.sub));
            end else begin
                bus64.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (nvalid != 16 || first != 9 || last != 24) begin
            errors++;
            $display("FAIL stream64_window got count=%0d first=%0d last=%0d expected 16 9 24",
                     nvalid, first, last);
        end
    endtask

    task automatic test_backpressure();
        logic [65:0] q [$];
        logic [65:0] got;
        logic [63:0] pa, pb, stall_sum;
        logic        pc, ps, pending;
        int          sent, popped;
        sent = 0; popped = 0; pending = 1'b0; stall_sum = '0;
        pa = '0; pb = '0; pc = 1'b0; ps = 1'b0;
        for (int t = 0; t < 60; t++) begin
            bus64.out_ready = !(t >= 12 && t < 15);
            if (sent < 20) begin
                if (!pending) begin
                    pa = rnd64(); pb = rnd64();
                    pc = $urandom_range(0, 1) == 1; ps = $urandom_range(0, 1) == 1;
                    pending = 1'b1;
                end
                bus64.a = pa; bus64.b = pb; bus64.cin = pc; bus64.sub = ps;
                bus64.in_valid = 1'b1;
            end else begin
                bus64.in_valid = 1'b0;
            end
            #1;
            if (t >= 12 && t < 15) begin
                if (t == 12) stall_sum = bus64.sum;
                checks++;
                if (bus64.in_ready !== 1'b0 || bus64.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall64 t=%0d got in_ready=%b out_valid=%b expected 0 1",
                             t, bus64.in_ready, bus64.out_valid);
                end
                if (t > 12) begin
                    checks++;
                    if (bus64.sum !== stall_sum) begin
                        errors++;
                        $display("FAIL hold64 t=%0d got %h expected %h", t, bus64.sum, stall_sum);
                    end
                end
            end
            if (bus64.out_valid === 1'b1) begin
                got = {bus64.ovf, bus64.cout, bus64.sum};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp64 t=%0d got unexpected result %h expected none", t, got);
                end else begin
                    if (got !== q[0]) begin
                        errors++;
                        $display("FAIL bp64 t=%0d got %h expected %h", t, got, q[0]);
                    end
                    if (bus64.out_ready) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            if (bus64.in_valid && bus64.in_ready === 1'b1) begin
                q.push_back(ref_add(64, pa, pb, pc, ps));
                sent++;
                pending = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus64.in_valid = 1'b0;
        bus64.out_ready = 1'b1;
        checks++;
        if (popped != 20 || q.size() != 0) begin
            errors++;
            $display("FAIL bp64_count got popped=%0d left=%0d expected 20 0", popped, q.size());
        end
    endtask

    task automatic test_reset_midstream();
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus64.a = rnd64(); bus64.b = rnd64(); bus64.cin = 1'b0; bus64.sub = 1'b0;
            bus64.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        // An operation offered during reset must be dropped too.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus64.in_valid = 1'b0;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || bus64.sum !== 64'd0) begin
            errors++;
            $display("FAIL midreset64 got vld=%b rdy=%b sum=%h expected 0 1 0",
                     bus64.out_valid, bus64.in_ready, bus64.sum);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus64.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset64_stale cycle %0d got out_valid=%b expected 0",
                         i, bus64.out_valid);
            end
        end
    endtask

    task automatic test_param_w32();
        logic [65:0] exp_r;
        logic [31:0] xa, xb;
        logic        xc, xs;
        int          lat;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                xa = 32'h7FFF_FFFF; xb = 32'd1; xc = 1'b0; xs = 1'b0;
            end else begin
                xa = $urandom(); xb = $urandom();
                xc = $urandom_range(0, 1) == 1; xs = $urandom_range(0, 1) == 1;
            end
            exp_r = ref_add(32, {32'd0, xa}, {32'd0, xb}, xc, xs);
            bus32.a = xa; bus32.b = xb; bus32.cin = xc; bus32.sub = xs;
            bus32.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus32.in_valid = 1'b0;
            lat = 0;
            while (bus32.out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL latency32 op%0d got %0d expected 1", i, lat);
            end
            checks++;
            if ({bus32.ovf, bus32.cout, bus32.sum} !== {exp_r[65:64], exp_r[31:0]}) begin
                errors++;
                $display("FAIL value32 op%0d got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                         i, bus32.ovf, bus32.cout, bus32.sum, exp_r[65], exp_r[64], exp_r[31:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_param_w16();
        logic [17:0] q [$];
        logic [65:0] exp_r;
        logic [15:0] corner [5];
        logic [15:0] pa, pb;
        logic        pc, ps, pending;
        int          lat, sent, popped, budget;
        localparam int N = 3000;
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
        corner[3] = 16'h8000; corner[4] = 16'hFFFF;
        bus16.out_ready = 1'b1;
        // Latency with an idle pipe.
        for (int i = 0; i < 2; i++) begin
            pa = $urandom(); pb = $urandom(); pc = i[0]; ps = i[0];
            exp_r = ref_add(16, {48'd0, pa}, {48'd0, pb}, pc, ps);
            bus16.a = pa; bus16.b = pb; bus16.cin = pc; bus16.sub = ps;
            bus16.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            lat = 0;
            while (bus16.out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat != 4 || {bus16.ovf, bus16.cout, bus16.sum} !== {exp_r[65:64], exp_r[15:0]}) begin
                errors++;
                $display("FAIL latency16 op%0d got lat=%0d res=%h expected lat=4 res=%h",
                         i, lat, {bus16.ovf, bus16.cout, bus16.sum}, {exp_r[65:64], exp_r[15:0]});
            end
            @(posedge clk);
            #1;
        end
        // Corner sweep followed by random traffic with random stalls.
        sent = 0; popped = 0; pending = 1'b0; budget = 0;
        pa = '0; pb = '0; pc = 1'b0; ps = 1'b0;
        while (popped < N && budget < 20000) begin
            bus16.out_ready = $urandom_range(0, 9) < 7;
            if (!pending && sent < N) begin
                if (sent < 100) begin
                    pa = corner[(sent / 20) % 5]; pb = corner[(sent / 4) % 5];
                    ps = sent[1]; pc = sent[0];
                end else begin
                    pa = $urandom(); pb = $urandom();
                    pc = $urandom_range(0, 1) == 1; ps = $urandom_range(0, 1) == 1;
                end
                pending = 1'b1;
            end
            bus16.a = pa; bus16.b = pb; bus16.cin = pc; bus16.sub = ps;
            bus16.in_valid = pending && ($urandom_range(0, 9) < 8);
            #1;
            if (bus16.out_valid === 1'b1 && bus16.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream16 got unexpected result %h expected none",
                             {bus16.ovf, bus16.cout, bus16.sum});
                end else begin
                    if ({bus16.ovf, bus16.cout, bus16.sum} !== q[0]) begin
                        errors++;
                        $display("FAIL stream16 result %0d got %h expected %h",
                                 popped, {bus16.ovf, bus16.cout, bus16.sum}, q[0]);
                    end
                    void'(q.pop_front());
                end
                popped++;
            end
            if (bus16.in_valid && bus16.in_ready === 1'b1) begin
                exp_r = ref_add(16, {48'd0, pa}, {48'd0, pb}, pc, ps);
                q.push_back({exp_r[65:64], exp_r[15:0]});
                sent++;
                pending = 1'b0;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        checks++;
        if (popped != N || q.size() != 0) begin
            errors++;
            $display("FAIL stream16_count got popped=%0d left=%0d expected %0d 0",
                     popped, q.size(), N);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.cin = 1'b0;
        bus64.sub = 1'b0; bus64.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
        bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus16.sub = 1'b0; bus16.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_param_w32();
        test_param_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
